// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access kinds, write-back selects and FSM states.
package mem_stage_pkg;

    typedef logic [2:0] memlen_t;
    localparam memlen_t MEMLEN_W  = 3'b000;
    localparam memlen_t MEMLEN_H  = 3'b001;
    localparam memlen_t MEMLEN_HU = 3'b010;
    localparam memlen_t MEMLEN_B  = 3'b011;
    localparam memlen_t MEMLEN_BU = 3'b100;

    typedef logic [1:0] cregwd_t;
    localparam cregwd_t CREGWD_ALU = 2'b00;
    localparam cregwd_t CREGWD_MEM = 2'b01;

    typedef logic cregwa_t;
    localparam cregwa_t CREGWA_RT = 1'b0;
    localparam cregwa_t CREGWA_RD = 1'b1;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_ACCESS = 1'b1;

    // Wait-counter value seen on the last ACCESS cycle before a bus error (255 cycles total).
    localparam logic [7:0] WAIT_LAST = 8'd254;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the memory.
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for stores, load extraction/extension, and alignment checking.
module mem_align
    import mem_stage_pkg::*;
(
    input  memlen_t     i_memlen,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_ldata      = i_rdata;
        o_misaligned = 1'b0;
        case (i_memlen)
            MEMLEN_H, MEMLEN_HU: begin
                o_be         = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_ldata      = (i_memlen == MEMLEN_H) ? {{16{w_half[15]}}, w_half}
                                                      : {16'h0000, w_half};
                o_misaligned = i_lane[0];
            end
            MEMLEN_B, MEMLEN_BU: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_ldata = (i_memlen == MEMLEN_B) ? {{24{w_byte[7]}}, w_byte}
                                                 : {24'h000000, w_byte};
            end
            // Word access; unused encodings are treated as words.
            default: o_misaligned = |i_lane;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-memory accesses, stalls upstream while one is
// outstanding, and registers the write-back result with forwarding taps.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic         flush_i,
    input  logic         cregwa_i,
    input  logic [1:0]   cregwd_i,
    input  logic         regwe_i,
    input  logic [2:0]   memlen_i,
    input  logic         memwe_i,
    input  logic [31:0]  rd2_i,
    input  logic [4:0]   rt_i,
    input  logic [4:0]   rd_i,
    input  logic [31:0]  aluout_i,
    mem_stage_if.master  dmem,
    output logic         stall_o,
    output logic         valid_o,
    output logic         regwe_o,
    output logic [4:0]   wa_o,
    output logic [31:0]  wd_o,
    output logic [1:0]   cwd_mem,
    output logic         we_mem,
    output logic [4:0]   wa_mem,
    output logic [31:0]  wd_mem,
    output logic         adel_o,
    output logic         ades_o,
    output logic         buserr_o
);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_lat_regwe;
    logic [4:0]  r_lat_wa;
    logic [1:0]  r_lat_cwd;
    memlen_t     r_lat_len;
    logic [1:0]  r_lat_lane;
    logic [31:0] r_lat_alu;
    logic        r_valid, r_regwe, r_adel, r_ades, r_buserr;
    logic [4:0]  r_wa;
    logic [31:0] r_wd;
    logic [1:0]  r_cwd;

    logic        w_idle, w_mem_op, w_start, w_timeout, w_misaligned;
    memlen_t     w_len;
    logic [1:0]  w_lane;
    logic [4:0]  w_wa_in;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ldata;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_mem_op  = valid_i & (memwe_i | (cregwd_i == CREGWD_MEM));
    // One aligner serves both phases: incoming op in IDLE, latched op during ACCESS.
    assign w_len     = w_idle ? memlen_i : r_lat_len;
    assign w_lane    = w_idle ? aluout_i[1:0] : r_lat_lane;
    assign w_start   = w_idle & w_mem_op & ~flush_i & ~w_misaligned;
    assign w_wa_in   = (cregwa_i == CREGWA_RD) ? rd_i : rt_i;
    assign w_timeout = ~w_idle & ~dmem.dmem_ack & (r_cnt == WAIT_LAST);

    mem_align u_align (
        .i_memlen     (w_len),
        .i_lane       (w_lane),
        .i_wdata      (rd2_i),
        .i_rdata      (dmem.dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_ldata      (w_ldata),
        .o_misaligned (w_misaligned)
    );

    assign stall_o         = w_start | ~w_idle;
    assign dmem.dmem_req   = ~w_idle;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;

    assign valid_o  = r_valid;
    assign regwe_o  = r_regwe;
    assign wa_o     = r_wa;
    assign wd_o     = r_wd;
    assign adel_o   = r_adel;
    assign ades_o   = r_ades;
    assign buserr_o = r_buserr;
    assign cwd_mem  = r_cwd;
    assign we_mem   = r_valid & r_regwe;
    assign wa_mem   = r_wa;
    assign wd_mem   = r_wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_be        <= 4'h0;
            r_wdata     <= 32'h0;
            r_lat_regwe <= 1'b0;
            r_lat_wa    <= 5'd0;
            r_lat_cwd   <= 2'b00;
            r_lat_len   <= MEMLEN_W;
            r_lat_lane  <= 2'b00;
            r_lat_alu   <= 32'h0;
            r_valid     <= 1'b0;
            r_regwe     <= 1'b0;
            r_adel      <= 1'b0;
            r_ades      <= 1'b0;
            r_buserr    <= 1'b0;
            r_wa        <= 5'd0;
            r_wd        <= 32'h0;
            r_cwd       <= 2'b00;
        end else begin
            r_valid  <= 1'b0;
            r_regwe  <= 1'b0;
            r_adel   <= 1'b0;
            r_ades   <= 1'b0;
            r_buserr <= 1'b0;
            if (w_idle) begin
                r_cnt <= 8'd0;
                if (w_start) begin
                    r_state     <= ST_ACCESS;
                    r_we        <= memwe_i;
                    r_addr      <= {aluout_i[31:2], 2'b00};
                    r_be        <= w_be;
                    r_wdata     <= w_wdata;
                    r_lat_regwe <= regwe_i;
                    r_lat_wa    <= w_wa_in;
                    r_lat_cwd   <= cregwd_i;
                    r_lat_len   <= memlen_i;
                    r_lat_lane  <= aluout_i[1:0];
                    r_lat_alu   <= aluout_i;
                end else if (valid_i && !flush_i) begin
                    r_valid <= 1'b1;
                    r_wa    <= w_wa_in;
                    r_wd    <= aluout_i;
                    r_cwd   <= cregwd_i;
                    // A memory op reaching here is misaligned and never touches the bus.
                    if (w_mem_op) begin
                        r_adel <= ~memwe_i;
                        r_ades <= memwe_i;
                    end else begin
                        r_regwe <= regwe_i;
                    end
                end
            end else if (dmem.dmem_ack || w_timeout) begin
                r_state  <= ST_IDLE;
                r_cnt    <= 8'd0;
                r_valid  <= 1'b1;
                r_wa     <= r_lat_wa;
                r_cwd    <= r_lat_cwd;
                r_wd     <= (dmem.dmem_ack && (r_lat_cwd == CREGWD_MEM)) ? w_ldata : r_lat_alu;
                r_regwe  <= dmem.dmem_ack & r_lat_regwe;
                r_buserr <= ~dmem.dmem_ack;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected results and bus transactions;
// a monitor and a memory responder pop and compare them independently.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk, rst;
    logic        valid_i, flush_i, cregwa_i, regwe_i, memwe_i;
    logic [1:0]  cregwd_i;
    logic [2:0]  memlen_i;
    logic [31:0] rd2_i, aluout_i;
    logic [4:0]  rt_i, rd_i;
    logic        stall_o, valid_o, regwe_o, we_mem, adel_o, ades_o, buserr_o;
    logic [4:0]  wa_o, wa_mem;
    logic [31:0] wd_o, wd_mem;
    logic [1:0]  cwd_mem;
    logic        resp_ack, stray_ack;

    mem_stage_if dmem_bus ();
    assign dmem_bus.dmem_ack = resp_ack | stray_ack;

    mem_stage u_dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .flush_i  (flush_i),
        .cregwa_i (cregwa_i),
        .cregwd_i (cregwd_i),
        .regwe_i  (regwe_i),
        .memlen_i (memlen_i),
        .memwe_i  (memwe_i),
        .rd2_i    (rd2_i),
        .rt_i     (rt_i),
        .rd_i     (rd_i),
        .aluout_i (aluout_i),
        .dmem     (dmem_bus.master),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .regwe_o  (regwe_o),
        .wa_o     (wa_o),
        .wd_o     (wd_o),
        .cwd_mem  (cwd_mem),
        .we_mem   (we_mem),
        .wa_mem   (wa_mem),
        .wd_mem   (wd_mem),
        .adel_o   (adel_o),
        .ades_o   (ades_o),
        .buserr_o (buserr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regwe;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  cwd;
        logic        adel, ades, buserr;
        bit          chk_data;
        string       name;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        string       name;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   ack_delay = 0;
    int   req_cyc = 0;
    int   last_req_len = 0;
    int   total_req = 0;
    logic bus_stable;
    bus_t cur_bus;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic regwe, input logic [4:0] wa, input logic [31:0] wd,
                            input logic [1:0] cwd, input logic adel, input logic ades,
                            input logic buserr, input bit chk_data, input string name);
        exp_t e;
        e.regwe = regwe; e.wa = wa; e.wd = wd; e.cwd = cwd;
        e.adel = adel; e.ades = ades; e.buserr = buserr;
        e.chk_data = chk_data; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input string name);
        bus_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.name = name;
        bus_q.push_back(b);
    endtask

    // Result monitor.
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_regwe"}, 32'(regwe_o), 32'(e.regwe));
                check({e.name, "_we_mem"}, 32'(we_mem), 32'(e.regwe));
                check({e.name, "_cwd"}, 32'(cwd_mem), 32'(e.cwd));
                check({e.name, "_exc"}, {29'd0, adel_o, ades_o, buserr_o},
                      {29'd0, e.adel, e.ades, e.buserr});
                if (e.chk_data) begin
                    check({e.name, "_wa"}, 32'(wa_o), 32'(e.wa));
                    check({e.name, "_wd"}, wd_o, e.wd);
                    check({e.name, "_wa_mem"}, 32'(wa_mem), 32'(e.wa));
                    check({e.name, "_wd_mem"}, wd_mem, e.wd);
                end
            end
        end
    end

    // Memory responder: checks each request against the queue and acks after ack_delay cycles.
    always @(negedge clk) begin
        if (dmem_bus.dmem_req) begin
            req_cyc++;
            if (req_cyc == 1) begin
                total_req++;
                bus_stable = 1'b1;
                cur_bus.we = dmem_bus.dmem_we;
                cur_bus.addr = dmem_bus.dmem_addr;
                cur_bus.be = dmem_bus.dmem_be;
                cur_bus.wdata = dmem_bus.dmem_wdata;
                if (bus_q.size() == 0) begin
                    check("unexpected_req", 32'(dmem_bus.dmem_req), 32'd0);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    check({b.name, "_we"}, 32'(dmem_bus.dmem_we), 32'(b.we));
                    check({b.name, "_addr"}, dmem_bus.dmem_addr, b.addr);
                    check({b.name, "_be"}, 32'(dmem_bus.dmem_be), 32'(b.be));
                    check({b.name, "_wdata"}, dmem_bus.dmem_wdata, b.wdata);
                end
            end else if (dmem_bus.dmem_we !== cur_bus.we || dmem_bus.dmem_addr !== cur_bus.addr ||
                         dmem_bus.dmem_be !== cur_bus.be ||
                         dmem_bus.dmem_wdata !== cur_bus.wdata) begin
                bus_stable = 1'b0;
            end
            resp_ack = (ack_delay != 0) && (req_cyc == ack_delay);
        end else begin
            if (req_cyc != 0) begin
                check("bus_stable", 32'(bus_stable), 32'd1);
                last_req_len = req_cyc;
            end
            req_cyc = 0;
            resp_ack = 1'b0;
        end
    end

    // Presents one op for a single cycle, then waits for stall_o to clear (bounded).
    task automatic issue(input logic [1:0] cwd, input logic cwa, input logic we_reg,
                         input logic [2:0] len, input logic mwe, input logic [31:0] rd2,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] alu,
                         input logic fl, output int stalls);
        logic s;
        int   guard;
        valid_i = 1'b1; cregwd_i = cwd; cregwa_i = cwa; regwe_i = we_reg; memlen_i = len;
        memwe_i = mwe; rd2_i = rd2; rt_i = rt; rd_i = rd; aluout_i = alu; flush_i = fl;
        #1 s = stall_o;
        stalls = s ? 1 : 0;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        guard = 0;
        while (s && guard < 400) begin
            #1 s = stall_o;
            if (s) stalls++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) check("stall_bound", 32'(s), 32'd0);
    endtask

    initial begin
        int st;
        int req_before;
        clk = 1'b0; rst = 1'b1;
        valid_i = 1'b0; flush_i = 1'b0; cregwa_i = 1'b0; cregwd_i = 2'b00; regwe_i = 1'b0;
        memlen_i = 3'b000; memwe_i = 1'b0; rd2_i = 32'h0; rt_i = 5'd0; rd_i = 5'd0;
        aluout_i = 32'h0; stray_ack = 1'b0; resp_ack = 1'b0; dmem_bus.dmem_rdata = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
        check("rst_outs", {27'd0, valid_o, regwe_o, adel_o, ades_o, buserr_o}, 32'd0);
        check("rst_bus", dmem_bus.dmem_addr | dmem_bus.dmem_wdata | 32'(dmem_bus.dmem_be), 32'd0);
        check("rst_wb", wd_o | 32'(wa_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        push_exp(1'b1, 5'd5, 32'h1234, CREGWD_ALU, 1'b0, 1'b0, 1'b0, 1'b1, "alu_rd");
        issue(CREGWD_ALU, CREGWA_RD, 1'b1, MEMLEN_W, 1'b0, 32'h0, 5'd7, 5'd5, 32'h1234, 1'b0, st);
        check("alu_stall", 32'(st), 32'd0);
        check("alu_latency", 32'(valid_o), 32'd1);

        push_exp(1'b1, 5'd9, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, "alu_rt");
        stray_ack = 1'b1;
        issue(2'b10, CREGWA_RT, 1'b1, MEMLEN_W, 1'b0, 32'h0, 5'd9, 5'd4, 32'hDEADBEEF, 1'b0, st);
        stray_ack = 1'b0;

        ack_delay = 3; dmem_bus.dmem_rdata = 32'h80123456;
        push_bus(1'b0, 32'h100, 4'b1000, 32'h0, "lb_bus");
        push_exp(1'b1, 5'd3, 32'hFFFFFF80, CREGWD_MEM, 1'b0, 1'b0, 1'b0, 1'b1, "lb");
        issue(CREGWD_MEM, CREGWA_RT, 1'b1, MEMLEN_B, 1'b0, 32'h0, 5'd3, 5'd1, 32'h103, 1'b0, st);
        check("lb_stall", 32'(st), 32'd4);

        push_bus(1'b0, 32'h100, 4'b1000, 32'h0, "lbu_bus");
        push_exp(1'b1, 5'd3, 32'h00000080, CREGWD_MEM, 1'b0, 1'b0, 1'b0, 1'b1, "lbu");
        issue(CREGWD_MEM, CREGWA_RT, 1'b1, MEMLEN_BU, 1'b0, 32'h0, 5'd3, 5'd1, 32'h103, 1'b0, st);

        ack_delay = 2; dmem_bus.dmem_rdata = 32'h80011234;
        push_bus(1'b0, 32'h100, 4'b1100, 32'h0, "lh_bus");
        push_exp(1'b1, 5'd6, 32'hFFFF8001, CREGWD_MEM, 1'b0, 1'b0, 1'b0, 1'b1, "lh");
        issue(CREGWD_MEM, CREGWA_RD, 1'b1, MEMLEN_H, 1'b0, 32'h0, 5'd2, 5'd6, 32'h102, 1'b0, st);

        dmem_bus.dmem_rdata = 32'h1234F00D;
        push_bus(1'b0, 32'h100, 4'b0011, 32'h0, "lhu_bus");
        push_exp(1'b1, 5'd6, 32'h0000F00D, CREGWD_MEM, 1'b0, 1'b0, 1'b0, 1'b1, "lhu");
        issue(CREGWD_MEM, CREGWA_RD, 1'b1, MEMLEN_HU, 1'b0, 32'h0, 5'd2, 5'd6, 32'h100, 1'b0, st);

        ack_delay = 1; dmem_bus.dmem_rdata = 32'hCAFEF00D;
        push_bus(1'b0, 32'h204, 4'b1111, 32'h0, "lw_bus");
        push_exp(1'b1, 5'd8, 32'hCAFEF00D, CREGWD_MEM, 1'b0, 1'b0, 1'b0, 1'b1, "lw");
        issue(CREGWD_MEM, CREGWA_RT, 1'b1, MEMLEN_W, 1'b0, 32'h0, 5'd8, 5'd1, 32'h204, 1'b0, st);
        check("lw_stall", 32'(st), 32'd2);

        ack_delay = 2;
        push_bus(1'b1, 32'h100, 4'b1100, 32'hABCDABCD, "sh_bus");
        push_exp(1'b0, 5'd0, 32'h102, CREGWD_ALU, 1'b0, 1'b0, 1'b0, 1'b1, "sh");
        issue(CREGWD_ALU, CREGWA_RT, 1'b0, MEMLEN_H, 1'b1, 32'h0000ABCD, 5'd0, 5'd0, 32'h102,
              1'b0, st);
        check("sh_stall", 32'(st), 32'd3);

        push_bus(1'b1, 32'h100, 4'b0010, 32'h5A5A5A5A, "sb_bus");
        push_exp(1'b0, 5'd0, 32'h101, CREGWD_ALU, 1'b0, 1'b0, 1'b0, 1'b1, "sb");
        issue(CREGWD_ALU, CREGWA_RT, 1'b0, MEMLEN_B, 1'b1, 32'h0000005A, 5'd0, 5'd0, 32'h101,
              1'b0, st);

        push_bus(1'b1, 32'h300, 4'b1111, 32'h11223344, "sw_bus");
        push_exp(1'b0, 5'd0, 32'h300, CREGWD_ALU, 1'b0, 1'b0, 1'b0, 1'b1, "sw");
        issue(CREGWD_ALU, CREGWA_RT, 1'b0, MEMLEN_W, 1'b1, 32'h11223344, 5'd0, 5'd0, 32'h300,
              1'b0, st);

        req_before = total_req;
        push_exp(1'b0, 5'd0, 32'h0, CREGWD_MEM, 1'b1, 1'b0, 1'b0, 1'b0, "lw_misal");
        issue(CREGWD_MEM, CREGWA_RT, 1'b1, MEMLEN_W, 1'b0, 32'h0, 5'd4, 5'd0, 32'h101, 1'b0, st);
        check("lw_misal_stall", 32'(st), 32'd0);
        push_exp(1'b0, 5'd0, 32'h0, CREGWD_ALU, 1'b0, 1'b1, 1'b0, 1'b0, "sh_misal");
        issue(CREGWD_ALU, CREGWA_RT, 1'b0, MEMLEN_H, 1'b1, 32'h0, 5'd0, 5'd0, 32'h103, 1'b0, st);
        check("misal_no_req", 32'(total_req), 32'(req_before));

        issue(CREGWD_ALU, CREGWA_RD, 1'b1, MEMLEN_W, 1'b0, 32'h0, 5'd0, 5'd12, 32'h55, 1'b1, st);
        check("flush_valid", {30'd0, valid_o, regwe_o}, 32'd0);

        ack_delay = 0;
        push_bus(1'b0, 32'h200, 4'b1111, 32'h0, "to_bus");
        push_exp(1'b0, 5'd0, 32'h0, CREGWD_MEM, 1'b0, 1'b0, 1'b1, 1'b0, "timeout");
        issue(CREGWD_MEM, CREGWA_RT, 1'b1, MEMLEN_W, 1'b0, 32'h0, 5'd3, 5'd0, 32'h200, 1'b0, st);
        check("timeout_stall", 32'(st), 32'd256);
        check("timeout_req_len", 32'(last_req_len), 32'd255);

        // Reset while the request is outstanding: bus drops at once and nothing is reported.
        push_bus(1'b0, 32'h400, 4'b1111, 32'h0, "rst_bus");
        valid_i = 1'b1; cregwd_i = CREGWD_MEM; cregwa_i = CREGWA_RT; regwe_i = 1'b1;
        memlen_i = MEMLEN_W; memwe_i = 1'b0; aluout_i = 32'h400; rt_i = 5'd2;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_req", 32'(dmem_bus.dmem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(dmem_bus.dmem_req), 32'd0);
        check("mid_rst_valid", {30'd0, valid_o, stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {30'd0, valid_o, dmem_bus.dmem_req}, 32'd0);

        push_exp(1'b1, 5'd17, 32'h00C0FFEE, CREGWD_ALU, 1'b0, 1'b0, 1'b0, 1'b1, "recover");
        issue(CREGWD_ALU, CREGWA_RD, 1'b1, MEMLEN_W, 1'b0, 32'h0, 5'd1, 5'd17, 32'h00C0FFEE,
              1'b0, st);
        repeat (2) @(negedge clk);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
